button_conditioner: RTL and testbench

Conditions a raw push-button input into clean, single-cycle press and release events for the CPU peripherals. It sits directly upstream of the timer peripheral: `press` drives the timer's `button` input, so one physical press produces exactly one capture request. The block synchronises the asynchronous pad, rejects contact bounce with a counter-based state machine, and optionally generates auto-repeat presses while the button is held.

---
 rtl/button_pkg.sv | 17 +
 rtl/btn_sync.sv | 28 ++
 rtl/button_conditioner.sv | 154 +++++++++++++++
 tb/tb_button_conditioner.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and 50 MHz defaults for the push-button conditioner.
package button_pkg;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  // Defaults for a 50 MHz system clock.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
  localparam int unsigned DEF_HOLD_CYCLES     = 25000000;  // 500 ms before first repeat
  localparam int unsigned DEF_REPEAT_CYCLES   = 5000000;   // 100 ms between repeats

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous pad, with a configurable
// synchronous reset value.
module btn_sync #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  // Metastability chain: first stage may go metastable, second resolves it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: polarity fix, 2-flop synchroniser, counter-based
// debounce FSM, registered level plus single-cycle press/release events.
// Optional auto-repeat of press while held is enabled by defining
// BUTTON_REPEAT_EN. The release event port is called release_pulse because
// "release" is a reserved word in SystemVerilog.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 20,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic press,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic   p;
  logic   s;
  state_t state;
  state_t state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic   press_next;
  logic   release_next;
  logic   level_next;
  logic   repeat_fire;

  assign p = ACTIVE_LOW ? ~btn_raw : btn_raw;

  btn_sync #(
    .RST_VAL (1'b0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (p),
    .q   (s)
  );

  // State, debounce counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      btn_level     <= level_next;
      press         <= press_next;
      release_pulse <= release_next;
    end
  end

  // Debounce decisions: a level change is accepted only after the counter
  // has seen DEBOUNCE_CYCLES consecutive samples; any bounce restarts it.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_next = PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt >= DEB_LIMIT) begin
          state_next = PRESSED;
          cnt_next   = '0;
          press_next = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end else if (repeat_fire) begin
          press_next = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt >= DEB_LIMIT) begin
          state_next   = IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
  end

`ifdef BUTTON_REPEAT_EN
  localparam int unsigned HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_target;
  logic              repeating;

  // First gap is HOLD_CYCLES, later gaps REPEAT_CYCLES; the count is the
  // number of cycles since the last press pulse, so fire one cycle early.
  assign hold_target = repeating ? HOLD_W'(REPEAT_CYCLES - 1) : HOLD_W'(HOLD_CYCLES - 1);
  // The !press term keeps consecutive press pulses apart even for tiny gaps.
  assign repeat_fire = (state == PRESSED) && (hold_cnt >= hold_target) && !press;

  // Hold timer: restarts on every press, keeps running through release
  // bounce (saturating), and is cleared only when the button is idle.
  always_ff @(posedge clk) begin
    if (rst || (state_next == IDLE)) begin
      hold_cnt  <= '0;
      repeating <= 1'b0;
    end else if (press_next) begin
      hold_cnt  <= '0;
      repeating <= repeating | (state == PRESSED);
    end else if (((state == PRESSED) || (state == RELEASE_WAIT)) && (hold_cnt < hold_target)) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end
`else
  logic unused_repeat_cfg;

  assign repeat_fire       = 1'b0;
  assign unused_repeat_cfg = (HOLD_CYCLES == REPEAT_CYCLES);
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised bench for button_conditioner with a run-length reference model
// and directed scenarios that pin exact event cycles.
module tb_button_conditioner;

  localparam int unsigned D    = 4;
  localparam int unsigned CW   = 8;
  localparam int unsigned HOLD = 20;
  localparam int unsigned REP  = 8;
  localparam bit          AL   = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b1;
  logic btn_level;
  logic press;
  logic release_pulse;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Event records gathered by the compare process.
  int n_press = 0;
  int n_rel   = 0;
  int last_press_cyc = -1;
  int last_rel_cyc   = -1;
  int rise_cyc = -1;
  int fall_cyc = -1;
  int press_log[$];
  logic prev_press = 1'b0;
  logic prev_level = 1'b0;

  // Reference model state.
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_L = 1'b0;
  int   m_run = 0;
  logic m_press = 1'b0;
  logic m_rel = 1'b0;
`ifdef BUTTON_REPEAT_EN
  int   m_since = 0;
  logic m_rep = 1'b0;
`endif

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (CW),
    .ACTIVE_LOW      (AL),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press         (press),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: the pad reaches the debouncer two edges late; a level
  // change is accepted once D+1 consecutive samples disagree with the
  // accepted level. Auto-repeat fires after the hold/repeat gap while the
  // button sits accepted-pressed and stable.
  always begin
    @(posedge clk);
    cyc = cyc + 1;
    if (rst) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_L = 1'b0; m_run = 0;
      m_press = 1'b0; m_rel = 1'b0;
`ifdef BUTTON_REPEAT_EN
      m_since = 0; m_rep = 1'b0;
`endif
    end else begin
      logic s_cur;
      logic ep;
      logic er;
      int   run_old;
      s_cur = m_s2; ep = 1'b0; er = 1'b0; run_old = m_run;
      if (s_cur != m_L) begin
        m_run = m_run + 1;
`ifdef BUTTON_REPEAT_EN
        m_since = m_since + 1;
`endif
        if (m_run == int'(D) + 1) begin
          m_L = s_cur;
          m_run = 0;
          if (m_L) begin
            ep = 1'b1;
`ifdef BUTTON_REPEAT_EN
            m_since = 0; m_rep = 1'b0;
`endif
          end else begin
            er = 1'b1;
          end
        end
      end else begin
        m_run = 0;
`ifdef BUTTON_REPEAT_EN
        if (m_L && run_old == 0 && !m_press && (m_since + 1 >= int'(m_rep ? REP : HOLD))) begin
          ep = 1'b1; m_since = 0; m_rep = 1'b1;
        end else begin
          m_since = m_since + 1;
        end
`else
        if (run_old < 0) ep = 1'b0;
`endif
      end
      m_s2 = m_s1;
      m_s1 = AL ? ~btn_raw : btn_raw;
      m_press = ep;
      m_rel = er;
    end
  end

  // Compare process: every cycle, mid-period.
  always begin
    @(negedge clk);
    if (cyc > 0) begin
      check("press", press, m_press);
      check("release", release_pulse, m_rel);
      check("btn_level", btn_level, m_L);
      check("press_release_exclusive", press & release_pulse, 0);
      check("press_back_to_back", press & prev_press, 0);
      if (press) begin
        n_press++; last_press_cyc = cyc; press_log.push_back(cyc);
      end
      if (release_pulse) begin
        n_rel++; last_rel_cyc = cyc;
      end
      if (btn_level && !prev_level) rise_cyc = cyc;
      if (!btn_level && prev_level) fall_cyc = cyc;
      prev_press = press;
      prev_level = btn_level;
    end
  end

  initial begin
    int n0;
    int p0;
    int r0;
    int q0;
    int t;
    int offs[4];
    offs[0] = 0; offs[1] = 20; offs[2] = 28; offs[3] = 36;

    // Reset state
    rst = 1'b1; btn_raw = 1'b1;
    tick(3);
    check("reset_level", btn_level, 0);
    check("reset_press", press, 0);
    check("reset_release", release_pulse, 0);
    rst = 1'b0;
    tick(5);

    // Clean press: event 6 cycles after the sampling cycle
    p0 = n_press; n0 = cyc + 1; btn_raw = 1'b0;
    tick(12);
    check("clean_press_count", n_press - p0, 1);
    check("clean_press_cycle", last_press_cyc, n0 + 6);
    check("clean_level_rise", rise_cyc, n0 + 6);

    // Release with a 2-cycle glitch back to pressed
    p0 = n_press; r0 = n_rel;
    btn_raw = 1'b1; tick(2);
    btn_raw = 1'b0; tick(2);
    n0 = cyc + 1; btn_raw = 1'b1;
    tick(12);
    check("glitch_release_count", n_rel - r0, 1);
    check("glitch_release_cycle", last_rel_cyc, n0 + 6);
    check("glitch_level_fall", fall_cyc, n0 + 6);
    check("glitch_no_press", n_press - p0, 0);

    // Bounce on press
    p0 = n_press;
    btn_raw = 1'b0; tick(3);
    btn_raw = 1'b1; tick(1);
    btn_raw = 1'b0; tick(3);
    btn_raw = 1'b1; tick(1);
    n0 = cyc + 1; btn_raw = 1'b0;
    tick(12);
    check("bounce_press_count", n_press - p0, 1);
    check("bounce_press_cycle", last_press_cyc, n0 + 6);
    btn_raw = 1'b1; tick(12);

    // Reset during PRESS_WAIT, button held through and after reset
    p0 = n_press; r0 = n_rel;
    btn_raw = 1'b0; tick(4);
    rst = 1'b1; tick(1);
    check("midrst_level", btn_level, 0);
    check("midrst_press", press, 0);
    check("midrst_release", release_pulse, 0);
    n0 = cyc + 1; rst = 1'b0;
    tick(12);
    check("midrst_press_count", n_press - p0, 1);
    check("midrst_press_cycle", last_press_cyc, n0 + 6);

    // Reset while pressed issues no release
    r0 = n_rel;
    rst = 1'b1; tick(1);
    check("pressed_rst_level", btn_level, 0);
    btn_raw = 1'b1; rst = 1'b0;
    tick(12);
    check("pressed_rst_no_release", n_rel - r0, 0);

    // Long hold: auto-repeat when enabled, single press otherwise
    q0 = press_log.size(); p0 = n_press; r0 = n_rel;
    n0 = cyc + 1; t = n0 + 6; btn_raw = 1'b0;
    tick(t + 37 - cyc);
    btn_raw = 1'b1;
    tick(14);
`ifdef BUTTON_REPEAT_EN
    check("repeat_press_count", n_press - p0, 4);
    for (int i = 0; i < 4; i++)
      check("repeat_press_cycle", (q0 + i < press_log.size()) ? press_log[q0 + i] : -1, t + offs[i]);
`else
    check("hold_press_count", n_press - p0, 1);
    check("hold_press_cycle", (q0 < press_log.size()) ? press_log[q0] : -1, t + offs[0]);
`endif
    check("hold_release_count", n_rel - r0, 1);
    check("hold_release_cycle", last_rel_cyc, t + 44);

    // Randomised segments against the model
    repeat (400) begin
      int len;
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        tick(1 + int'($urandom_range(0, 2)));
        rst = 1'b0;
      end
      btn_raw = ~btn_raw;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 30)) : int'($urandom_range(1, 7));
      tick(len);
    end
    btn_raw = 1'b1;
    tick(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
